subband_gain_ramp_axis: RTL and testbench

//  NCH-channel AXI-Stream gain stage for QMF subband chains. Sits between qmf_analysis_axis and qmf_synthesis_axis.

---
 rtl/qmf_gain_pkg.sv | 13 +
 rtl/gain_ramp_lane.sv | 76 +++++++
 rtl/subband_gain_ramp_axis.sv | 79 +++++++
 tb/tb_subband_gain_ramp_axis.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qmf_gain_pkg.sv
// qmf_gain_pkg: register map, control bits and arithmetic helpers for the subband gain stage
package qmf_gain_pkg;
  localparam int REG_CTRL      = 'h00;
  localparam int REG_GAIN_BASE = 'h04;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_RAMP_BIT = 1;
  function automatic logic [31:0] unity_gain(input int fbits);
    return 32'd1 << fbits;
  endfunction
  function automatic logic [15:0] sat16(input logic signed [47:0] v);
    return (v > 48'sd32767) ? 16'h7fff : (v < -48'sd32768) ? 16'h8000 : v[15:0];
  endfunction
endpackage

// File: rtl/gain_ramp_lane.sv
// gain_ramp_lane: one stream channel, ramped current gain plus a 2-stage multiply/round pipeline
module gain_ramp_lane
  import qmf_gain_pkg::*;
#(
  parameter int GAIN_W     = 16,
  parameter int GAIN_FBITS = 12,
  parameter int RAMP_SHIFT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_tdata_i,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  input  logic              s_tlast_i,
  output logic [31:0]       m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tlast_o,
  input  logic [GAIN_W-1:0] target_i,
  input  logic              enable_i,
  input  logic              ramp_en_i
);
  localparam int PW = 16 + GAIN_W;
  localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FBITS));
  logic signed [GAIN_W-1:0] cur_q, cur_d, gain;
  logic signed [GAIN_W:0]   diff, step0, step;
  logic signed [PW-1:0]     ph_q, pl_q, ph_d, pl_d;
  logic [31:0]              md_q, md_d;
  logic                     v1_q, l1_q, mv_q, ml_q, adv, acc;
  function automatic logic [15:0] rnd_sat(input logic signed [PW-1:0] p);
    logic signed [47:0] w;
    w = 48'(p) + (48'sd1 <<< (GAIN_FBITS - 1));
    return sat16(w >>> GAIN_FBITS);
  endfunction
  assign adv        = !mv_q | m_tready_i;
  assign acc        = s_tvalid_i & adv;
  assign s_tready_o = adv;
  assign m_tdata_o  = md_q;
  assign m_tvalid_o = mv_q;
  assign m_tlast_o  = ml_q;
  // Ramp step toward target and stage products; bypass multiplies by unity so it is bit-exact
  always_comb begin
    diff  = $signed({target_i[GAIN_W-1], target_i}) - $signed({cur_q[GAIN_W-1], cur_q});
    step0 = diff >>> RAMP_SHIFT;
    step  = (step0 == '0 && diff != '0) ? (diff[GAIN_W] ? '1 : (GAIN_W+1)'(1)) : step0;
    cur_d = !acc ? cur_q : ramp_en_i ? GAIN_W'(cur_q + step) : $signed(target_i);
    gain  = enable_i ? cur_q : UNITY;
    ph_d  = PW'($signed(s_tdata_i[31:16])) * PW'(gain);
    pl_d  = PW'($signed(s_tdata_i[15:0])) * PW'(gain);
    md_d  = {rnd_sat(ph_q), rnd_sat(pl_q)};
  end
  // Gain state and both pipeline stages; a stall freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= UNITY;
      v1_q  <= 1'b0;
      l1_q  <= 1'b0;
      ph_q  <= '0;
      pl_q  <= '0;
      mv_q  <= 1'b0;
      ml_q  <= 1'b0;
      md_q  <= '0;
    end else begin
      cur_q <= cur_d;
      if (adv) begin
        v1_q <= s_tvalid_i;
        l1_q <= s_tvalid_i & s_tlast_i;
        ph_q <= ph_d;
        pl_q <= pl_d;
        mv_q <= v1_q;
        ml_q <= l1_q;
        md_q <= md_d;
      end
    end
  end
endmodule

// File: rtl/subband_gain_ramp_axis.sv
// subband_gain_ramp_axis: AXI-Lite register file and per-channel gain ramp lanes
module subband_gain_ramp_axis
  import qmf_gain_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int GAIN_W     = 16,
  parameter int GAIN_FBITS = 12,
  parameter int RAMP_SHIFT = 6,
  parameter int ADDRW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*32-1:0] s_axis_tdata,
  input  logic [NCH-1:0]    s_axis_tvalid,
  output logic [NCH-1:0]    s_axis_tready,
  input  logic [NCH-1:0]    s_axis_tlast,
  output logic [NCH*32-1:0] m_axis_tdata,
  output logic [NCH-1:0]    m_axis_tvalid,
  input  logic [NCH-1:0]    m_axis_tready,
  output logic [NCH-1:0]    m_axis_tlast,
  input  logic [ADDRW-1:0]  s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              s_axi_arready,
  output logic              s_axi_rvalid
);
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FBITS));
  logic       wr, bvalid_q;
  logic [1:0] ctrl_q;
  assign wr            = s_axi_awvalid & s_axi_wvalid & !bvalid_q;
  assign s_axi_awready = wr;
  assign s_axi_wready  = wr;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = 1'b0;
  assign s_axi_rvalid  = 1'b0;
  // CTRL register and write response; bvalid holds until bready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      if (wr && s_axi_awaddr == ADDRW'(REG_CTRL))
        ctrl_q <= {s_axi_wdata[CTRL_RAMP_BIT], s_axi_wdata[CTRL_EN_BIT]};
      bvalid_q <= wr | (bvalid_q & !s_axi_bready);
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [GAIN_W-1:0] tgt_q;
    // Target gain register for this channel
    always_ff @(posedge clk or posedge rst) begin
      if (rst) tgt_q <= UNITY;
      else if (wr && s_axi_awaddr == ADDRW'(REG_GAIN_BASE + 4 * c)) tgt_q <= s_axi_wdata[GAIN_W-1:0];
    end
    gain_ramp_lane #(
      .GAIN_W    (GAIN_W),
      .GAIN_FBITS(GAIN_FBITS),
      .RAMP_SHIFT(RAMP_SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .s_tdata_i (s_axis_tdata[32*c+:32]),
      .s_tvalid_i(s_axis_tvalid[c]),
      .s_tready_o(s_axis_tready[c]),
      .s_tlast_i (s_axis_tlast[c]),
      .m_tdata_o (m_axis_tdata[32*c+:32]),
      .m_tvalid_o(m_axis_tvalid[c]),
      .m_tready_i(m_axis_tready[c]),
      .m_tlast_o (m_axis_tlast[c]),
      .target_i  (tgt_q),
      .enable_i  (ctrl_q[CTRL_EN_BIT]),
      .ramp_en_i (ctrl_q[CTRL_RAMP_BIT])
    );
  end
endmodule

// File: tb/tb_subband_gain_ramp_axis.sv
// tb_subband_gain_ramp_axis: randomized and directed checks against a behavioural gain model
module tb_subband_gain_ramp_axis;
  localparam int NCH = 2, GF = 12, RS = 2;
  logic clk = 0, rst;
  logic [NCH*32-1:0] s_axis_tdata, m_axis_tdata;
  logic [NCH-1:0] s_axis_tvalid, s_axis_tready, s_axis_tlast, m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0] s_axi_awaddr;
  logic [31:0] s_axi_wdata;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_arready, s_axi_rvalid;
  int n_chk = 0, n_fail = 0;
  longint cur[NCH], tgt[NCH];
  bit en, rmp;
  logic [32:0] exp_q[NCH][$];
  int nout[NCH];

  subband_gain_ramp_axis #(.NCH(NCH), .GAIN_W(16), .GAIN_FBITS(GF), .RAMP_SHIFT(RS), .ADDRW(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arready(s_axi_arready), .s_axi_rvalid(s_axi_rvalid));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b);
    return {16'(a), 16'(b)};
  endfunction

  // Reference: real-valued gain g/2^GF, round half up, clamp to 16-bit signed
  function automatic logic [15:0] scale(input logic [15:0] x, input longint g, input bit e);
    longint r;
    if (!e) return x;
    r = (longint'($signed(x)) * g + (longint'(1) << (GF - 1))) >>> GF;
    return r > 32767 ? 16'h7fff : r < -32768 ? 16'h8000 : r[15:0];
  endfunction

  // Scoreboard: predict each accepted beat, compare each delivered beat, track register writes
  always @(negedge clk) begin
    logic [32:0] e;
    longint d, st;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        exp_q[c].delete();
        cur[c] = 4096;
        tgt[c] = 4096;
      end
      en = 0;
      rmp = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_axis_tvalid[c] && m_axis_tready[c]) begin
          nout[c]++;
          if (exp_q[c].size() == 0) chk($sformatf("ch%0d unexpected beat", c), m_axis_tvalid[c], 0);
          else begin
            e = exp_q[c].pop_front();
            chk($sformatf("ch%0d beat", c), {m_axis_tlast[c], m_axis_tdata[32*c+:32]}, e);
          end
        end
        if (s_axis_tvalid[c] && s_axis_tready[c]) begin
          exp_q[c].push_back({s_axis_tlast[c], scale(s_axis_tdata[32*c+16+:16], cur[c], en),
                              scale(s_axis_tdata[32*c+:16], cur[c], en)});
          d = tgt[c] - cur[c];
          st = d >>> RS;
          if (st == 0 && d != 0) st = d > 0 ? 1 : -1;
          cur[c] = rmp ? cur[c] + st : tgt[c];
        end
      end
      if (s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid) begin
        if (s_axi_awaddr == 8'h00) begin
          en = s_axi_wdata[0];
          rmp = s_axi_wdata[1];
        end
        for (int c = 0; c < NCH; c++)
          if (s_axi_awaddr == 8'(4 + 4 * c)) tgt[c] = longint'($signed(s_axi_wdata[15:0]));
      end
    end
  end

  task automatic send(input int c, input logic [31:0] d, input logic l);
    int k;
    s_axis_tdata[32*c+:32] = d;
    s_axis_tlast[c] = l;
    s_axis_tvalid[c] = 1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_axis_tready[c]) break;
    end
    if (k == 50) chk($sformatf("ch%0d accept timeout", c), s_axis_tready[c], 1);
    @(posedge clk); #1;
    s_axis_tvalid[c] = 0;
    s_axis_tlast[c] = 0;
  endtask

  task automatic get_out(input int c, output logic [32:0] o, output int lat);
    lat = -1;
    o = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_axis_tvalid[c] && m_axis_tready[c]) begin
        o = {m_axis_tlast[c], m_axis_tdata[32*c+:32]};
        lat = k;
        break;
      end
    end
    if (lat < 0) chk($sformatf("ch%0d output timeout", c), m_axis_tvalid[c], 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d);
    int k;
    s_axi_awaddr = a;
    s_axi_wdata = d;
    s_axi_awvalid = 1;
    s_axi_wvalid = 1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_axi_awready && s_axi_wready) break;
    end
    if (k == 20) chk("aw/w accept timeout", s_axi_awready, 1);
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    s_axi_wvalid = 0;
    chk("bvalid set", s_axi_bvalid, 1);
    @(posedge clk); #1;
    chk("bvalid held without bready", s_axi_bvalid, 1);
    s_axi_bready = 1;
    @(posedge clk); #1;
    s_axi_bready = 0;
    chk("bvalid clear", s_axi_bvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [32:0] o;
    int lat, sent[NCH], n0[NCH], mx;
    logic [15:0] g[40];
    logic acc[NCH], awf, stall1;
    rst = 1;
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; m_axis_tready = '1;
    s_axi_awaddr = 0; s_axi_wdata = 0; s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
    repeat (3) @(posedge clk); #1;
    chk("reset m_tvalid", m_axis_tvalid, 0);
    chk("reset m_tdata", m_axis_tdata, 0);
    chk("reset bvalid", s_axi_bvalid, 0);
    chk("reset arready/rvalid", {s_axi_arready, s_axi_rvalid}, 0);
    rst = 0;
    @(posedge clk); #1;
    // bypass
    send(0, pk(1000, -1000), 1);
    get_out(0, o, lat);
    chk("bypass data", o, {1'b1, pk(1000, -1000)});
    chk("bypass latency", lat, 1);
    // saturation, gain 2.0
    axi_wr(8'h04, 32'h2000);
    axi_wr(8'h00, 32'h1);
    send(0, pk(0, 0), 0); get_out(0, o, lat);
    send(0, pk(20000, -20000), 0); get_out(0, o, lat);
    chk("saturate", o, {1'b0, pk(32767, -32768)});
    send(0, pk(1000, -3), 1); get_out(0, o, lat);
    chk("gain 2", o, {1'b1, pk(2000, -6)});
    // rounding, gain 0.25 on ch1
    axi_wr(8'h08, 32'h0400);
    send(1, pk(0, 0), 0); get_out(1, o, lat);
    send(1, pk(1000, -1000), 0); get_out(1, o, lat);
    chk("quarter", o, {1'b0, pk(250, -250)});
    axi_wr(8'h80, 32'h7fff);
    send(1, pk(3, -3), 0); get_out(1, o, lat);
    chk("round small", o, {1'b0, pk(1, -1)});
    // ramp 0x1000 -> 0x2000
    axi_wr(8'h04, 32'h1000);
    send(0, pk(0, 0), 0); get_out(0, o, lat);
    axi_wr(8'h00, 32'h3);
    axi_wr(8'h04, 32'h2000);
    mx = 0;
    for (int i = 0; i < 40; i++) begin
      send(0, pk(4096, 4096), 0);
      get_out(0, o, lat);
      g[i] = o[15:0];
      if (int'(g[i]) > mx) mx = int'(g[i]);
    end
    chk("ramp beat0", g[0], 16'h1000);
    chk("ramp beat1", g[1], 16'h1400);
    chk("ramp beat2", g[2], 16'h1700);
    chk("ramp beat3", g[3], 16'h1940);
    chk("ramp converged", g[38], 16'h2000);
    chk("ramp holds", g[39], 16'h2000);
    chk("ramp no overshoot", mx, 32'h2000);
    // random backpressure on ch0, ch1 always ready, retargets mid-stream
    axi_wr(8'h04, 32'($urandom_range(0, 16'h3fff)));
    axi_wr(8'h08, 32'($urandom_range(0, 16'h3fff)));
    for (int c = 0; c < NCH; c++) begin sent[c] = 0; n0[c] = nout[c]; end
    s_axi_bready = 1;
    stall1 = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (sent[0] == 500 && sent[1] == 500 && s_axis_tvalid == 0) break;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) acc[c] = s_axis_tvalid[c] & s_axis_tready[c];
      if (!s_axis_tready[1]) stall1 = 1;
      awf = s_axi_awready;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (acc[c]) begin s_axis_tvalid[c] = 0; s_axis_tlast[c] = 0; end
        if (!s_axis_tvalid[c] && sent[c] < 500 && $urandom_range(0, 3) != 0) begin
          s_axis_tdata[32*c+:32] = $urandom;
          s_axis_tlast[c] = (sent[c] % 16) == 15;
          s_axis_tvalid[c] = 1;
          sent[c]++;
        end
      end
      m_axis_tready[0] = 1'($urandom_range(0, 1));
      if (awf) begin s_axi_awvalid = 0; s_axi_wvalid = 0; end
      if (cyc == 150 || cyc == 400) begin
        s_axi_awaddr = cyc == 150 ? 8'h04 : 8'h08;
        s_axi_wdata = $urandom;
        s_axi_awvalid = 1;
        s_axi_wvalid = 1;
      end
      if (cyc == 600) begin
        s_axi_awaddr = 8'h00; s_axi_wdata = 32'h1; s_axi_awvalid = 1; s_axi_wvalid = 1;
      end
    end
    m_axis_tready = '1;
    repeat (10) @(posedge clk); #1;
    s_axi_bready = 0;
    chk("ch0 beat count", nout[0] - n0[0], 500);
    chk("ch1 beat count", nout[1] - n0[1], 500);
    chk("ch0 leftover", exp_q[0].size(), 0);
    chk("ch1 leftover", exp_q[1].size(), 0);
    chk("ch1 isolation", stall1, 0);
    // reset mid-stream
    axi_wr(8'h00, 32'h1);
    axi_wr(8'h04, 32'h0800);
    send(0, pk(0, 0), 0); get_out(0, o, lat);
    for (int i = 0; i < 7; i++) begin
      s_axis_tdata[31:0] = pk(100 * i, -100 * i);
      s_axis_tvalid[0] = 1;
      @(posedge clk); #1;
    end
    s_axis_tvalid[0] = 0;
    chk("pre-reset m_tvalid", m_axis_tvalid[0], 1);
    rst = 1;
    #1;
    chk("mid-stream reset m_tvalid", m_axis_tvalid, 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    send(0, pk(1234, -5678), 1); get_out(0, o, lat);
    chk("post-reset ctrl off", o, {1'b1, pk(1234, -5678)});
    axi_wr(8'h00, 32'h1);
    send(0, pk(1234, -5678), 0); get_out(0, o, lat);
    chk("post-reset unity gain", o, {1'b0, pk(1234, -5678)});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
